dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller sitting directly downstream of the pipeline's EX/MEM register, serving loads and stores from the MEM stage. It drives the `CacheHit` and stall indications consumed by the hazard unit. On a miss it refills a full line from main data memory over a simple req/ready handshake. Byte/half accesses are out of scope: word accesses only, with `cpu_addr[1:0]` ignored.

## Interface
- `LINES`, 16, number of cache lines (power of two, ≥2)
- `WORDS`, 4, words per line (power of two, ≥2)
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `cpu_read`  in  1  MEM-stage load request (`mem_read_out` of EX/MEM)
- `cpu_write`  in  1  MEM-stage store request (`mem_write_out` of EX/MEM)
- `cpu_addr`  in  32  byte address (ALU result)
- `cpu_wdata`  in  32  store data
- `cpu_rdata`  out  32  load data
- `cpu_stall`  out  1  freeze IF/ID/EX/MEM; inputs held stable while high
- `cache_hit`  out  1  lookup hit this cycle
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  32  word-aligned memory address
- `mem_wdata`  out  32  memory write data
- `mem_ready`  in  1  memory accepts/completes request this cycle
- `mem_rdata`  in  32  read data, valid when `mem_req & ~mem_we & mem_ready`
- `stat_hits`, `stat_misses`  out  32 each  counters (see Configuration)

## Operation
- Address split: offset = `cpu_addr[log2(WORDS)+1:2]`, index = next `log2(LINES)` bits, tag = remaining upper bits.
- Storage: per line a valid bit, a tag, and `WORDS`×32 data.
- States: IDLE, REFILL, WRITE.
- IDLE, no request: `cpu_stall`=0, `cache_hit`=0, `mem_req`=0.
- IDLE, read hit: `cpu_rdata` = cached word combinationally; `cache_hit`=1; `cpu_stall`=0; stay in IDLE.
- IDLE, read miss: `cpu_stall`=1, `cache_hit`=0; go to REFILL with beat counter = 0.
- REFILL: `mem_req`=1, `mem_we`=0, `mem_addr` = {tag, index, beat, 2'b00}. On each `mem_ready`, write `mem_rdata` into word `beat` and increment beat. On the last beat, write the tag, set valid, and return to IDLE. `cpu_stall`=1 throughout. The held load then hits in IDLE.
- Refill always starts at word 0 (no critical-word-first).
- IDLE, write (hit or miss): `cpu_stall`=1; go to WRITE.
- WRITE: `mem_req`=1, `mem_we`=1, `mem_addr` = {`cpu_addr[31:2]`, 2'b00}, `mem_wdata` = `cpu_wdata`. `cpu_stall` = `~mem_ready`. On `mem_ready`: if the line is valid with a matching tag, update the cached word; return to IDLE. A write miss leaves the cache untouched.
- `cache_hit` in WRITE reflects tag match.
- `cpu_read` and `cpu_write` both high: treated as write.
- Refill replaces the line unconditionally (write-through, so no writeback is needed).
- Reset (async, any state, including mid-refill or mid-write): all valid bits cleared, state IDLE, beat 0, counters 0. Data/tag arrays are not reset.

## Timing
- Reset values: `cpu_stall`=0, `cache_hit`=0, `cpu_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, stats 0.
- `cpu_rdata` is 0 whenever there is no read hit.
- Read hit: 0 cycles added.
- Read miss with `mem_ready` held high: stall for WORDS+1 cycles (detect cycle + WORDS beats); data returned in the following IDLE cycle.
- Each `mem_ready` wait cycle adds one stall cycle.
- Store with `mem_ready` held high: stall for 1 cycle (IDLE detect); the WRITE cycle completes with stall low.
- Memory outputs are combinational from state and registers only; `mem_req` is never asserted in IDLE.
- Beat counter wraps to 0 after the last beat.

## Configuration
- `DCACHE_STATS_EN` defined: `stat_hits` increments on every IDLE read hit. `stat_misses` increments on every IDLE read miss (counted once per miss, not per stall cycle). Both counters wrap at 2^32 and clear on reset.
- Not defined: `stat_hits` and `stat_misses` are tied to 0 and no counter flops are built.

## Test plan
- Reset pulse at arbitrary time → all outputs 0; a read of 0x100 afterwards misses.
- Read 0x100 with `mem_ready`=1 and `mem_rdata` = address → 4 beats at 0x100/104/108/10C; stall for 5 cycles; then `cpu_rdata`=0x100, `cache_hit`=1. A following read of 0x108 hits with 0x108 and no stall.
- Write 0xDEADBEEF to 0x104 after that fill → one memory write at 0x104, 1 stall cycle; a read of 0x104 then hits with 0xDEADBEEF. Write to 0x500 (miss) → memory write only; a read of 0x500 misses.
- Conflict: read 0x100, then 0x500 (same index, LINES=16, WORDS=4) → second access refills; a re-read of 0x100 misses again.
- `mem_ready` low for 3 cycles on beat 2 → stall extends by 3 cycles and data is correct. Reset asserted mid-refill → state IDLE; a re-read of the same address misses and refills from word 0.
- With `DCACHE_STATS_EN`: 3 hits and 2 misses → `stat_hits`=3, `stat_misses`=2. Without the macro → both 0.

Source files
------------

// File: rtl/dcache_if.sv
// dcache_if: MEM-stage load/store port and main-memory port of the data cache.
// master = pipeline/memory side, slave = cache controller.
interface dcache_if;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cache_hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output mem_ready, mem_rdata,
    input  cpu_rdata, cpu_stall, cache_hit,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  mem_ready, mem_rdata,
    output cpu_rdata, cpu_stall, cache_hit,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate data cache.
// Define DCACHE_STATS_EN to build the hit/miss counters.
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  dcache_if.slave     bus,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t            state;
  logic [OW-1:0]     beat;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tag_q  [LINES];
  logic [31:0]       data_q [LINES][WORDS];

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          rd;
  logic          wr;
  logic          hit;
  logic          last;
  logic          unused_addr;

  assign off  = bus.cpu_addr[OW+1:2];
  assign idx  = bus.cpu_addr[OW+IW+1:OW+2];
  assign tag  = bus.cpu_addr[31:OW+IW+2];
  assign wr   = bus.cpu_write;
  assign rd   = bus.cpu_read & ~bus.cpu_write;
  assign hit  = valid[idx] & (tag_q[idx] == tag);
  assign last = (beat == OW'(WORDS-1));
  assign unused_addr = ^bus.cpu_addr[1:0];

  // Stall, hit and memory-port decode from state and current request
  always_comb begin
    bus.cpu_rdata = '0;
    bus.cpu_stall = 1'b0;
    bus.cache_hit = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      IDLE: begin
        bus.cpu_stall = wr | (rd & ~hit);
        bus.cache_hit = (rd | wr) & hit;
        if (rd && hit) bus.cpu_rdata = data_q[idx][off];
      end
      REFILL: begin
        bus.cpu_stall = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = {tag, idx, beat, 2'b00};
      end
      WRITE: begin
        bus.cpu_stall = ~bus.mem_ready;
        bus.cache_hit = hit;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {bus.cpu_addr[31:2], 2'b00};
        bus.mem_wdata = bus.cpu_wdata;
      end
      default: ;
    endcase
  end

  // Controller FSM, beat counter and valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
      valid <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr) begin
            state <= WRITE;
          end else if (rd && !hit) begin
            state      <= REFILL;
            beat       <= '0;
            valid[idx] <= 1'b0;
          end
        end
        REFILL: begin
          if (bus.mem_ready) begin
            beat <= beat + OW'(1);
            if (last) begin
              valid[idx] <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays: refill beats and write-through updates on hit
  always_ff @(posedge clk) begin
    if (state == REFILL && bus.mem_ready) begin
      data_q[idx][beat] <= bus.mem_rdata;
      if (last) tag_q[idx] <= tag;
    end
    if (state == WRITE && bus.mem_ready && hit)
      data_q[idx][off] <= bus.cpu_wdata;
  end

`ifdef DCACHE_STATS_EN
  // Count each IDLE read lookup once as hit or miss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == IDLE && rd) begin
      if (hit) stat_hits   <= stat_hits + 32'd1;
      else     stat_misses <= stat_misses + 32'd1;
    end
  end
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl (LINES=16, WORDS=4).
// Memory model returns the word address unless overwritten by a store.
module tb_dcache_ctrl;
  localparam int WORDS = 4;

  typedef struct packed {
    logic        to;
    logic [7:0]  st;
    logic [31:0] d;
    logic        h;
  } rres_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dcache_if ifc ();
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;

  dcache_ctrl #(.LINES(16), .WORDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (ifc),
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
  );

  rres_t       exp_q [$];
  logic [31:0] beat_q[$];
  logic [31:0] mem   [1024];
  int          total = 0;
  int          bad = 0;
  int          wr_n = 0;
  logic [31:0] wr_a = '0;
  logic [31:0] wr_d = '0;
  int          hold_beat = -1;
  int          hold_left = 0;
  logic        mv [16];
  logic [23:0] mt [16];
  int          hits_m = 0;
  int          miss_m = 0;

  assign ifc.mem_rdata = mem[ifc.mem_addr[11:2]];

  always @(posedge clk) begin
    if (ifc.mem_req === 1'b1 && ifc.mem_ready === 1'b1) begin
      if (ifc.mem_we) begin
        mem[ifc.mem_addr[11:2]] = ifc.mem_wdata;
        wr_n++;
        wr_a = ifc.mem_addr;
        wr_d = ifc.mem_wdata;
      end else begin
        beat_q.push_back(ifc.mem_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (ifc.mem_req === 1'b1 && ifc.mem_we === 1'b0 &&
        int'(ifc.mem_addr[3:2]) == hold_beat && hold_left > 0) begin
      ifc.mem_ready = 1'b0;
      hold_left--;
    end else begin
      ifc.mem_ready = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic rres_t predict(input logic [31:0] a, input int extra);
    rres_t r;
    logic [3:0] i;
    logic [23:0] t;
    i = a[7:4];
    t = a[31:8];
    r.to = 1'b0;
    r.d = mem[a[11:2]];
    r.h = 1'b1;
    if (mv[i] && mt[i] == t) begin
      r.st = 8'd0;
    end else begin
      r.st = 8'(WORDS + 1 + extra);
      mv[i] = 1'b1;
      mt[i] = t;
      miss_m++;
    end
    hits_m++;
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    hits_m = 0;
    miss_m = 0;
  endtask

  task automatic drive_read(input logic [31:0] a, output rres_t r);
    r = '0;
    r.to = 1'b1;
    ifc.cpu_addr = a;
    ifc.cpu_read = 1'b1;
    ifc.cpu_write = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.cpu_stall === 1'b0) begin
        r.d = ifc.cpu_rdata;
        r.h = ifc.cache_hit;
        r.to = 1'b0;
        break;
      end
      r.st++;
    end
    @(posedge clk);
    #1;
    ifc.cpu_read = 1'b0;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d,
                             input logic rd, output logic [8:0] r);
    r = 9'h100;
    ifc.cpu_addr = a;
    ifc.cpu_wdata = d;
    ifc.cpu_read = rd;
    ifc.cpu_write = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.cpu_stall === 1'b0) begin
        r[8] = 1'b0;
        break;
      end
      r[7:0] = r[7:0] + 8'd1;
    end
    @(posedge clk);
    #1;
    ifc.cpu_write = 1'b0;
    ifc.cpu_read = 1'b0;
  endtask

  task automatic apply_reset();
    ifc.cpu_read = 1'b0;
    ifc.cpu_write = 1'b0;
    #3 reset = 1'b1;
    #7 reset = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [163:0] o;
    ifc.cpu_read = 1'b0;
    ifc.cpu_write = 1'b0;
    ifc.cpu_addr = '0;
    ifc.cpu_wdata = '0;
    #3 reset = 1'b1;
    #1;
    o = {ifc.cpu_stall, ifc.cache_hit, ifc.cpu_rdata, ifc.mem_req, ifc.mem_we,
         ifc.mem_addr, ifc.mem_wdata, stat_hits, stat_misses};
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL reset_hold outputs=%h want 0", o);
    end
    #17 reset = 1'b0;
    clear_model();
    @(negedge clk);
    o = {ifc.cpu_stall, ifc.cache_hit, ifc.cpu_rdata, ifc.mem_req, ifc.mem_we,
         ifc.mem_addr, ifc.mem_wdata, stat_hits, stat_misses};
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL reset_idle outputs=%h want 0", o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_miss();
    logic [31:0] adr [2] = '{32'h100, 32'h108};
    rres_t g, e;
    beat_q.delete();
    foreach (adr[k]) begin
      exp_q.push_back(predict(adr[k], 0));
      drive_read(adr[k], g);
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL read_%h got to=%0d st=%0d d=%h h=%0d want to=%0d st=%0d d=%h h=%0d",
                 adr[k], g.to, g.st, g.d, g.h, e.to, e.st, e.d, e.h);
      end
    end
    total++;
    if (beat_q.size() != 4 || beat_q[0] !== 32'h100 || beat_q[1] !== 32'h104 ||
        beat_q[2] !== 32'h108 || beat_q[3] !== 32'h10C) begin
      bad++;
      $display("FAIL refill_beats got n=%0d first=%h want n=4 from 100",
               beat_q.size(), beat_q.size() > 0 ? beat_q[0] : 32'h0);
    end
  endtask

  task automatic test_write();
    logic [31:0] wa [2] = '{32'h104, 32'h500};
    logic [31:0] wd [2] = '{32'hDEADBEEF, 32'h5A5A0500};
    logic [8:0] w;
    rres_t g, e;
    int n0;
    foreach (wa[k]) begin
      n0 = wr_n;
      drive_write(wa[k], wd[k], 1'b0, w);
      total++;
      if (w !== 9'd1 || wr_n != n0 + 1 || wr_a !== wa[k] || wr_d !== wd[k]) begin
        bad++;
        $display("FAIL write_%h got stall=%0d n=%0d a=%h d=%h want stall=1 n=%0d a=%h d=%h",
                 wa[k], w, wr_n - n0, wr_a, wr_d, 1, 1, wa[k], wd[k]);
      end
      exp_q.push_back(predict(wa[k], 0));
      drive_read(wa[k], g);
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL wread_%h got to=%0d st=%0d d=%h h=%0d want to=%0d st=%0d d=%h h=%0d",
                 wa[k], g.to, g.st, g.d, g.h, e.to, e.st, e.d, e.h);
      end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] adr [4] = '{32'h100, 32'h500, 32'h100, 32'h104};
    rres_t g, e;
    foreach (adr[k]) exp_q.push_back(predict(adr[k], 0));
    foreach (adr[k]) begin
      drive_read(adr[k], g);
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL conflict_%0d got to=%0d st=%0d d=%h h=%0d want to=%0d st=%0d d=%h h=%0d",
                 k, g.to, g.st, g.d, g.h, e.to, e.st, e.d, e.h);
      end
    end
  endtask

  task automatic test_ready_wait();
    logic [31:0] adr [3] = '{32'h240, 32'h248, 32'h24C};
    int ext [3] = '{3, 0, 0};
    rres_t g, e;
    hold_beat = 2;
    hold_left = 3;
    foreach (adr[k]) exp_q.push_back(predict(adr[k], ext[k]));
    foreach (adr[k]) begin
      drive_read(adr[k], g);
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL wait_%h got to=%0d st=%0d d=%h h=%0d want to=%0d st=%0d d=%h h=%0d",
                 adr[k], g.to, g.st, g.d, g.h, e.to, e.st, e.d, e.h);
      end
    end
    hold_beat = -1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] adr [2] = '{32'h300, 32'h100};
    logic [70:0] o;
    rres_t g, e;
    int n;
    beat_q.delete();
    ifc.cpu_addr = 32'h300;
    ifc.cpu_read = 1'b1;
    n = 0;
    while (beat_q.size() < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (beat_q.size() < 2) begin
      bad++;
      $display("FAIL midfill_start got beats=%0d want 2", beat_q.size());
    end
    #2 reset = 1'b1;
    ifc.cpu_read = 1'b0;
    #1;
    o = {ifc.cpu_stall, ifc.cache_hit, ifc.mem_req, ifc.mem_we, ifc.mem_addr, ifc.cpu_rdata};
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL midfill_reset outputs=%h want 0", o);
    end
    #4 reset = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    beat_q.delete();
    foreach (adr[k]) begin
      exp_q.push_back(predict(adr[k], 0));
      drive_read(adr[k], g);
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL postreset_%h got to=%0d st=%0d d=%h h=%0d want to=%0d st=%0d d=%h h=%0d",
                 adr[k], g.to, g.st, g.d, g.h, e.to, e.st, e.d, e.h);
      end
    end
    total++;
    if (beat_q.size() != 8 || beat_q[0] !== 32'h300 || beat_q[1] !== 32'h304 ||
        beat_q[3] !== 32'h30C) begin
      bad++;
      $display("FAIL refill_restart got n=%0d first=%h want n=8 from 300",
               beat_q.size(), beat_q.size() > 0 ? beat_q[0] : 32'h0);
    end
  endtask

  task automatic test_rw_both();
    logic [8:0] w;
    rres_t g, e;
    int n0;
    n0 = wr_n;
    drive_write(32'h208, 32'h12345678, 1'b1, w);
    total++;
    if (w !== 9'd1 || wr_n != n0 + 1 || wr_a !== 32'h208 || wr_d !== 32'h12345678) begin
      bad++;
      $display("FAIL rw_both got stall=%0d n=%0d a=%h d=%h want stall=1 n=1 a=208 d=12345678",
               w, wr_n - n0, wr_a, wr_d);
    end
    exp_q.push_back(predict(32'h208, 0));
    drive_read(32'h208, g);
    e = exp_q.pop_front();
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL rw_read got to=%0d st=%0d d=%h h=%0d want to=%0d st=%0d d=%h h=%0d",
               g.to, g.st, g.d, g.h, e.to, e.st, e.d, e.h);
    end
  endtask

  task automatic test_stats();
    logic [31:0] adr [3] = '{32'h100, 32'h200, 32'h204};
    logic [63:0] want;
    rres_t g, e;
    apply_reset();
    foreach (adr[k]) begin
      exp_q.push_back(predict(adr[k], 0));
      drive_read(adr[k], g);
      e = exp_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL stats_rd_%h got to=%0d st=%0d d=%h h=%0d want to=%0d st=%0d d=%h h=%0d",
                 adr[k], g.to, g.st, g.d, g.h, e.to, e.st, e.d, e.h);
      end
    end
`ifdef DCACHE_STATS_EN
    want = {32'(hits_m), 32'(miss_m)};
`else
    want = 64'd0;
`endif
    total++;
    if ({stat_hits, stat_misses} !== want) begin
      bad++;
      $display("FAIL stats got hits=%0d misses=%0d want hits=%0d misses=%0d",
               stat_hits, stat_misses, want[63:32], want[31:0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 4);
    clear_model();
    test_reset();
    test_read_miss();
    test_write();
    test_conflict();
    test_ready_wait();
    test_reset_mid();
    test_rw_both();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
